if_fetch_unit: RTL and testbench

- Instruction-fetch stage and write side of the IF/ID instruction pipeline register.
- Owns the PC and issues requests to instruction memory over a request/ready handshake.
- Presents the fetched word plus a write strobe for IF/ID to latch.
- Honours hazard stalls from ID by buffering one returned word, and branch/jump redirects from later stages by discarding in-flight work and inserting a NOP bubble.

---
 rtl/if_fetch_unit_pkg.sv | 29 ++
 rtl/nbit_reg.sv | 29 ++
 rtl/if_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// ============================================================================
// Module  : if_fetch_unit_pkg
// Brief   : Shared fetch-stage constants, state encoding and PC helpers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package if_fetch_unit_pkg;

  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IF_PC_STEP  = 32'd4;
  localparam logic [31:0] IF_NOP_WORD = 32'h0000_0000;

  localparam int          STATE_W = 1;
  localparam logic [STATE_W-1:0] S_REQ  = 1'b0;
  localparam logic [STATE_W-1:0] S_HOLD = 1'b1;

  // Sequential successor; wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_next(input logic [31:0] pc, input logic [31:0] step);
    return pc + step;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/nbit_reg.sv
// ============================================================================
// Module  : nbit_reg
// Brief   : N-bit enabled register with synchronous active-high reset.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module nbit_reg #(
  parameter int            N         = 32,
  parameter logic [N-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module  : if_fetch_unit
// Brief   : Instruction fetch with stall buffering and redirect bubbles.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter logic [31:0] PC_STEP  = IF_PC_STEP,
  parameter logic [31:0] NOP_WORD = IF_NOP_WORD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] instructions,
  output logic [31:0] pcPlus4,
  output logic        writeEnable
);

  localparam logic [31:0] RESET_PC_PLUS = RESET_PC + PC_STEP;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_next;

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus;
  logic [31:0] w_pc_d;
  logic        w_pc_en;

  logic [31:0] r_hold_word;
  logic [31:0] r_hold_pc;
  logic [31:0] w_hold_word_d;
  logic        w_hold_en;

  logic        w_req_accept;
  logic        w_req_capture;
  logic        w_hold_release;

  assign w_pc_plus      = pc_next(r_pc, PC_STEP);
  assign w_req_accept   = (r_state == S_REQ)  && imemReady && !stall && !redirect;
  assign w_req_capture  = (r_state == S_REQ)  && imemReady &&  stall && !redirect;
  assign w_hold_release = (r_state == S_HOLD) && !stall && !redirect;

  // PC advances only once its word has actually been written into IF/ID.
  assign w_pc_en = w_req_accept || w_hold_release || redirect;

  always_comb begin
    w_pc_d = w_pc_plus;
    if (redirect) begin
      w_pc_d = word_align(redirectPC);
    end else if (r_state == S_HOLD) begin
      w_pc_d = r_hold_pc;
    end
  end

  nbit_reg #(.N(32), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk (Clk),
    .rst (Reset),
    .en  (w_pc_en),
    .d   (w_pc_d),
    .q   (r_pc)
  );

  // A redirect overwrites the buffer with a NOP so a stale word cannot leak out.
  assign w_hold_en     = w_req_capture || redirect;
  assign w_hold_word_d = redirect ? NOP_WORD : imemData;

  nbit_reg #(.N(32), .RESET_VAL(NOP_WORD)) u_hold_word_reg (
    .clk (Clk),
    .rst (Reset),
    .en  (w_hold_en),
    .d   (w_hold_word_d),
    .q   (r_hold_word)
  );

  nbit_reg #(.N(32), .RESET_VAL(RESET_PC_PLUS)) u_hold_pc_reg (
    .clk (Clk),
    .rst (Reset),
    .en  (w_req_capture),
    .d   (w_pc_plus),
    .q   (r_hold_pc)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (redirect) begin
      w_state_next = S_REQ;
    end else begin
      case (r_state)
        S_REQ:   if (imemReady && stall) w_state_next = S_HOLD;
        S_HOLD:  if (!stall)             w_state_next = S_REQ;
        default: w_state_next = S_REQ;
      endcase
    end
  end

  always_comb begin
    imemReq      = 1'b0;
    imemAddr     = r_pc;
    instructions = NOP_WORD;
    pcPlus4      = w_pc_plus;
    writeEnable  = 1'b0;
    if (Reset) begin
      pcPlus4 = RESET_PC_PLUS;
    end else if (redirect) begin
      imemReq     = (r_state == S_REQ);
      pcPlus4     = redirectPC;
      writeEnable = 1'b1;
    end else begin
      case (r_state)
        S_REQ: begin
          imemReq = 1'b1;
          if (imemReady) begin
            instructions = imemData;
            writeEnable  = !stall;
          end
        end
        S_HOLD: begin
          instructions = r_hold_word;
          pcPlus4      = r_hold_pc;
          writeEnable  = !stall;
        end
        default: begin
          imemReq = 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module  : tb_if_fetch_unit
// Brief   : Directed self-checking bench for if_fetch_unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic [31:0] instructions;
  logic [31:0] pcPlus4;
  logic        writeEnable;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  // Memory model: each word is its address xor a fixed key.
  assign imemData = imemAddr ^ KEY;

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirectPC   (redirectPC),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemReady    (imemReady),
    .imemData     (imemData),
    .instructions (instructions),
    .pcPlus4      (pcPlus4),
    .writeEnable  (writeEnable)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock, then drive inputs shortly after the edge.
  task automatic next_cycle(input logic rst, input logic stl, input logic rdy,
                            input logic rdr, input logic [31:0] rpc);
    @(posedge Clk);
    #1;
    Reset      = rst;
    stall      = stl;
    imemReady  = rdy;
    redirect   = rdr;
    redirectPC = rpc;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; stall = 1'b0; imemReady = 1'b0; redirect = 1'b0; redirectPC = '0;
    #2;
    check_eq("rst_req",   {31'd0, imemReq},     32'd0);
    check_eq("rst_we",    {31'd0, writeEnable}, 32'd0);
    check_eq("rst_instr", instructions,         32'h0);
    check_eq("rst_pcp4",  pcPlus4,              32'h4);
    next_cycle(1, 0, 1, 0, 0);

    // Zero-wait streaming.
    next_cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) next_cycle(0, 0, 1, 0, 0);
      check_eq("seq_addr",  imemAddr,              32'(i * 4));
      check_eq("seq_we",    {31'd0, writeEnable},  32'd1);
      check_eq("seq_instr", instructions,          32'(i * 4) ^ KEY);
      check_eq("seq_pcp4",  pcPlus4,               32'(i * 4 + 4));
    end

    // Memory wait states at 0x10.
    for (int i = 0; i < 3; i++) begin
      next_cycle(0, 0, 0, 0, 0);
      check_eq("wait_addr", imemAddr,             32'h10);
      check_eq("wait_we",   {31'd0, writeEnable}, 32'd0);
    end
    next_cycle(0, 0, 1, 0, 0);
    check_eq("wait_instr", instructions,         32'hA5A5_0010);
    check_eq("wait_pcp4",  pcPlus4,              32'h14);
    check_eq("wait_we1",   {31'd0, writeEnable}, 32'd1);

    // Stream 0x14..0x1C.
    for (int i = 0; i < 3; i++) next_cycle(0, 0, 1, 0, 0);

    // Stall while word@0x20 returns.
    next_cycle(0, 1, 1, 0, 0);
    check_eq("stl_addr", imemAddr,             32'h20);
    check_eq("stl_we0",  {31'd0, writeEnable}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      next_cycle(0, 1, 1, 0, 0);
      check_eq("hold_req",   {31'd0, imemReq},     32'd0);
      check_eq("hold_we",    {31'd0, writeEnable}, 32'd0);
      check_eq("hold_instr", instructions,         32'hA5A5_0020);
    end
    next_cycle(0, 0, 1, 0, 0);
    check_eq("rel_we",    {31'd0, writeEnable}, 32'd1);
    check_eq("rel_instr", instructions,         32'hA5A5_0020);
    check_eq("rel_pcp4",  pcPlus4,              32'h24);
    next_cycle(0, 1, 1, 0, 0);
    check_eq("rel_addr",  imemAddr,             32'h24);
    check_eq("rel_req",   {31'd0, imemReq},     32'd1);

    // Redirect while holding word@0x24.
    next_cycle(0, 1, 0, 1, 32'h0000_1003);
    check_eq("rdh_we",    {31'd0, writeEnable}, 32'd1);
    check_eq("rdh_instr", instructions,         32'h0);
    check_eq("rdh_pcp4",  pcPlus4,              32'h0000_1003);
    next_cycle(0, 0, 0, 0, 0);
    check_eq("rdh_addr",  imemAddr,             32'h0000_1000);
    check_eq("rdh_req",   {31'd0, imemReq},     32'd1);
    check_eq("rdh_we0",   {31'd0, writeEnable}, 32'd0);

    // Redirect colliding with ready for word@0x30.
    next_cycle(0, 0, 0, 1, 32'h30);
    next_cycle(0, 0, 1, 1, 32'h40);
    check_eq("rdr_addr",  imemAddr,             32'h30);
    check_eq("rdr_we",    {31'd0, writeEnable}, 32'd1);
    check_eq("rdr_instr", instructions,         32'h0);
    check_eq("rdr_pcp4",  pcPlus4,              32'h40);
    next_cycle(0, 0, 1, 0, 0);
    check_eq("rdr_addr2",  imemAddr,     32'h40);
    check_eq("rdr_instr2", instructions, 32'hA5A5_0040);
    check_eq("rdr_pcp42",  pcPlus4,      32'h44);

    // PC wrap.
    next_cycle(0, 0, 0, 1, 32'hFFFF_FFFC);
    next_cycle(0, 0, 1, 0, 0);
    check_eq("wrap_addr",  imemAddr,     32'hFFFF_FFFC);
    check_eq("wrap_instr", instructions, 32'h5A5A_FFFC);
    check_eq("wrap_pcp4",  pcPlus4,      32'h0);
    next_cycle(0, 1, 1, 0, 0);
    check_eq("wrap_addr2", imemAddr,     32'h0);

    // Reset in the middle of a stall.
    next_cycle(0, 1, 1, 0, 0);
    check_eq("mrst_hold", {31'd0, imemReq}, 32'd0);
    next_cycle(1, 1, 1, 0, 0);
    check_eq("mrst_we",   {31'd0, writeEnable}, 32'd0);
    check_eq("mrst_pcp4", pcPlus4,              32'h4);
    next_cycle(0, 0, 1, 0, 0);
    check_eq("mrst_addr",  imemAddr,             32'h0);
    check_eq("mrst_req",   {31'd0, imemReq},     32'd1);
    check_eq("mrst_instr", instructions,         32'hA5A5_0000);
    check_eq("mrst_pcp4b", pcPlus4,              32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
